// File: rtl/digit_scan_ctrl.sv
// digit_scan_ctrl
//   Multiplexed display scanner. It steps a 3-bit digit index 0..7, showing
//   each digit for DIV cycles and then blanking it for BLANK cycles, so the
//   segment lines can settle between digits. Digit codes come from a 32-bit
//   shadow register that is loaded by a one-cycle strobe.
//
// Parameters
//   DIV        cycles each digit is shown (1..65535)
//   BLANK      blanking cycles between digits (1..255)
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   run        level-sensitive scan enable
//   load       strobe: capture din into the shadow register
//   din        eight 4-bit codes, nibble k = din[4k+3:4k]
//   sel        current digit index (3-to-8 decoder input)
//   sel_en     decoder enable, high only while a digit is shown
//   digit      code of the digit at index sel
//   frame_done one-cycle pulse after each 7-to-0 index wrap
module digit_scan_ctrl #(
  parameter int DIV   = 4,
  parameter int BLANK = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  input  logic        load,
  input  logic [31:0] din,
  output logic [2:0]  sel,
  output logic        sel_en,
  output logic [3:0]  digit,
  output logic        frame_done
);

  // One counter serves both SHOW and BLANKING, so it is sized for the larger
  // of the two terminal counts.
  localparam int MAX_CNT = (DIV > BLANK) ? DIV : BLANK;
  localparam int CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;
  localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHOW,
    BLANKING
  } state_t;

  state_t           state_q, state_d;
  logic [31:0]      shadow_q, shadow_d;
  logic [2:0]       sel_q, sel_d;
  logic             sel_en_q, sel_en_d;
  logic [3:0]       digit_q, digit_d;
  logic             frame_done_q, frame_done_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       sel_inc;

  // Next-state and output logic. shadow_d already folds in a same-edge load,
  // so a digit fetched from it on SHOW entry sees the new din (bypass) rather
  // than the stale shadow contents. digit is only refreshed on SHOW entry so
  // a load mid-digit cannot tear the displayed value.
  always_comb begin
    state_d      = state_q;
    shadow_d     = load ? din : shadow_q;
    sel_d        = sel_q;
    sel_en_d     = sel_en_q;
    digit_d      = digit_q;
    frame_done_d = 1'b0;
    cnt_d        = cnt_q;
    sel_inc      = sel_q + 3'd1;

    case (state_q)
      IDLE: begin
        sel_d    = 3'd0;
        sel_en_d = 1'b0;
        cnt_d    = '0;
        if (run) begin
          state_d  = SHOW;
          sel_en_d = 1'b1;
          digit_d  = shadow_d[3:0];
        end
      end

      SHOW: begin
        if (!run) begin
          state_d  = IDLE;
          sel_d    = 3'd0;
          sel_en_d = 1'b0;
          cnt_d    = '0;
        end else if (cnt_q == DIV_LAST) begin
          state_d  = BLANKING;
          sel_en_d = 1'b0;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      BLANKING: begin
        if (!run) begin
          state_d  = IDLE;
          sel_d    = 3'd0;
          sel_en_d = 1'b0;
          cnt_d    = '0;
        end else if (cnt_q == BLANK_LAST) begin
          state_d      = SHOW;
          sel_d        = sel_inc;
          sel_en_d     = 1'b1;
          cnt_d        = '0;
          digit_d      = shadow_d[{sel_inc, 2'b00} +: 4];
          frame_done_d = (sel_q == 3'd7);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d  = IDLE;
        sel_d    = 3'd0;
        sel_en_d = 1'b0;
        cnt_d    = '0;
      end
    endcase
  end

  // State register. Reset is asynchronous so the decoder enable drops the
  // moment rst_n falls, and it also blocks any load on a reset edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      shadow_q     <= '0;
      sel_q        <= 3'd0;
      sel_en_q     <= 1'b0;
      digit_q      <= 4'd0;
      frame_done_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      shadow_q     <= shadow_d;
      sel_q        <= sel_d;
      sel_en_q     <= sel_en_d;
      digit_q      <= digit_d;
      frame_done_q <= frame_done_d;
      cnt_q        <= cnt_d;
    end
  end

  assign sel        = sel_q;
  assign sel_en     = sel_en_q;
  assign digit      = digit_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_digit_scan_ctrl.sv
// tb_digit_scan_ctrl
//   Self-checking bench for digit_scan_ctrl with DIV=4, BLANK=2. A reference
//   model derives the expected outputs from the elapsed scan time since the
//   last SHOW entry; a compare process checks every cycle, and directed
//   scenarios add literal expectations at key points.
module tb_digit_scan_ctrl;

  localparam int DIV   = 4;
  localparam int BLANK = 2;
  localparam int P     = DIV + BLANK;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        run = 1'b0;
  logic        load = 1'b0;
  logic [31:0] din = 32'd0;
  logic [2:0]  sel;
  logic        sel_en;
  logic [3:0]  digit;
  logic        frame_done;

  int nCompared = 0;
  int nMismatched = 0;

  digit_scan_ctrl #(.DIV(DIV), .BLANK(BLANK)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .run       (run),
    .load      (load),
    .din       (din),
    .sel       (sel),
    .sel_en    (sel_en),
    .digit     (digit),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Reference model: while scanning, mT counts edges since the SHOW entry
  // out of IDLE. Index and enable follow from plain division by the digit
  // period; the digit code is refetched each time a new period starts.
  logic        mRunning = 1'b0;
  int          mT = 0;
  logic [31:0] mShadow = 32'd0;
  logic [3:0]  mDigit = 4'd0;
  logic        mFrame = 1'b0;
  logic [31:0] mView;
  logic [2:0]  expSel;
  logic        expSelEn;

  assign mView    = load ? din : mShadow;
  assign expSel   = mRunning ? 3'((mT / P) % 8) : 3'd0;
  assign expSelEn = mRunning && ((mT % P) < DIV);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mRunning <= 1'b0;
      mT       <= 0;
      mShadow  <= 32'd0;
      mDigit   <= 4'd0;
      mFrame   <= 1'b0;
    end else begin
      mShadow <= mView;
      mFrame  <= 1'b0;
      if (!mRunning) begin
        if (run) begin
          mRunning <= 1'b1;
          mT       <= 0;
          mDigit   <= mView[3:0];
        end
      end else if (!run) begin
        mRunning <= 1'b0;
        mT       <= 0;
      end else begin
        mT <= mT + 1;
        if (((mT + 1) % P) == 0) begin
          mDigit <= mView[(((mT + 1) / P) % 8) * 4 +: 4];
          mFrame <= ((((mT + 1) / P) % 8) == 0);
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, on the falling edge.
  always @(negedge clk) begin
    checkOutput("sel", 32'(sel), 32'(expSel));
    checkOutput("sel_en", 32'(sel_en), 32'(expSelEn));
    checkOutput("digit", 32'(digit), 32'(mDigit));
    checkOutput("frame_done", 32'(frame_done), 32'(mFrame));
  end

  task automatic applyStimulus(input logic r, input logic l, input logic [31:0] d);
    run  = r;
    load = l;
    din  = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic        r;
    logic        l;
    logic [31:0] d;

    $display("[TB] start");
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_sel", 32'(sel), 32'd0);
    checkOutput("reset_sel_en", 32'(sel_en), 32'd0);
    checkOutput("reset_digit", 32'(digit), 32'd0);
    checkOutput("reset_frame_done", 32'(frame_done), 32'd0);
    rst_n = 1'b1;

    // Basic scan, frame wrap, load timing, bypass, stop/restart.
    applyStimulus(1'b0, 1'b1, 32'h7654_3210);
    applyStimulus(1'b1, 1'b0, 32'd0);
    checkOutput("entry_sel", 32'(sel), 32'd0);
    checkOutput("entry_sel_en", 32'(sel_en), 32'd1);
    checkOutput("entry_no_frame", 32'(frame_done), 32'd0);
    for (int k = 1; k <= 136; k++) begin
      r = (k <= 130) || (k >= 132);
      l = (k == 68) || (k == 90);
      d = (k == 68) ? 32'hFFFF_FFFF : (k == 90) ? 32'hA000_0000 : 32'd0;
      applyStimulus(r, l, d);
      case (k)
        3:   checkOutput("show_last_en", 32'(sel_en), 32'd1);
        4:   checkOutput("blank_en", 32'(sel_en), 32'd0);
        6:   begin
               checkOutput("sel1", 32'(sel), 32'd1);
               checkOutput("digit1", 32'(digit), 32'd1);
             end
        47:  checkOutput("sel7_blank", 32'(sel), 32'd7);
        48:  begin
               checkOutput("wrap_frame", 32'(frame_done), 32'd1);
               checkOutput("wrap_sel", 32'(sel), 32'd0);
             end
        49:  checkOutput("wrap_pulse_end", 32'(frame_done), 32'd0);
        71:  checkOutput("no_tear_digit", 32'(digit), 32'd3);
        72:  checkOutput("loaded_digit4", 32'(digit), 32'hF);
        90:  checkOutput("bypass_digit", 32'(digit), 32'hA);
        131: begin
               checkOutput("stop_sel", 32'(sel), 32'd0);
               checkOutput("stop_sel_en", 32'(sel_en), 32'd0);
             end
        132: begin
               checkOutput("restart_en", 32'(sel_en), 32'd1);
               checkOutput("restart_frame", 32'(frame_done), 32'd0);
             end
        135: checkOutput("restart_full", 32'(sel_en), 32'd1);
        136: checkOutput("restart_blank", 32'(sel_en), 32'd0);
        default: ;
      endcase
    end

    // Randomized traffic; the compare process does the checking.
    for (int i = 0; i < 4000; i++) begin
      r = ($urandom_range(0, 199) != 0);
      l = ($urandom_range(0, 15) == 0);
      d = $urandom;
      applyStimulus(r, l, d);
    end

    // Asynchronous reset in the middle of SHOW.
    applyStimulus(1'b0, 1'b1, 32'hFFFF_FFFF);
    applyStimulus(1'b1, 1'b0, 32'd0);
    checkOutput("pre_reset_digit", 32'(digit), 32'hF);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_sel_en", 32'(sel_en), 32'd0);
    checkOutput("async_sel", 32'(sel), 32'd0);
    checkOutput("async_digit", 32'(digit), 32'd0);
    load = 1'b1;
    din  = 32'h1234_5678;
    repeat (3) @(posedge clk);
    #1;
    load  = 1'b0;
    rst_n = 1'b1;
    applyStimulus(1'b1, 1'b0, 32'd0);
    checkOutput("post_reset_en", 32'(sel_en), 32'd1);
    checkOutput("post_reset_digit", 32'(digit), 32'd0);
    repeat (6) applyStimulus(1'b1, 1'b0, 32'd0);
    checkOutput("post_reset_sel1", 32'(sel), 32'd1);
    checkOutput("post_reset_digit1", 32'(digit), 32'd0);
    repeat (10) applyStimulus(1'b1, 1'b0, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
